// File: rtl/cpu_types_pkg.sv
// Shared types for the memory responder: RAM status, responder FSM states and the
// fill word returned when an access times out.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    RESP  = 2'd3
  } memfsm_t;

  localparam logic [31:0] MEM_TIMEOUT_WORD = 32'hDDDD_DDDD;

endpackage

// File: rtl/mem_req_responder_if.sv
// Datapath request/response and RAM-port signals of the memory responder.
// slave is the responder's view, master the view of whoever drives the requests and RAM.
interface mem_req_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic                     iREN;
  logic [ADDR_W-1:0]        iaddr;
  logic                     dREN;
  logic                     dWEN;
  logic [ADDR_W-1:0]        daddr;
  logic [DATA_W-1:0]        dstore;
  logic                     ihit;
  logic                     dhit;
  logic [DATA_W-1:0]        iload;
  logic [DATA_W-1:0]        dload;
  logic                     ramREN;
  logic                     ramWEN;
  logic [ADDR_W-1:0]        ramaddr;
  logic [DATA_W-1:0]        ramstore;
  logic [DATA_W-1:0]        ramload;
  cpu_types_pkg::ramstate_t ramstate;
  logic                     memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

endinterface

// File: rtl/mem_req_responder.sv
// Arbitrates fetch and data requests onto the single RAM port (data first), waits for
// ACCESS and returns the word with a one-cycle hit pulse. All outputs are registered.
module mem_req_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                CLK,
  input logic                RST,
  mem_req_responder_if.slave bus
);

  localparam int unsigned        CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]    CntMax   = CntW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0]  FillWord = {(DATA_W/4){4'hD}};

  memfsm_t             state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                ihit_q, ihit_d;
  logic                dhit_q, dhit_d;
  logic [DATA_W-1:0]   iload_q, iload_d;
  logic [DATA_W-1:0]   dload_q, dload_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   ramaddr_q, ramaddr_d;
  logic [DATA_W-1:0]   ramstore_q, ramstore_d;
  logic                memerr_q, memerr_d;
  logic                done;
  logic [DATA_W-1:0]   rdata;

  // ramaddr/ramstore double as the latched transaction, so an ERROR retry simply keeps them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ren_d      = 1'b0;
    wen_d      = 1'b0;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    memerr_d   = memerr_q;
    done       = 1'b0;
    rdata      = bus.ramload;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.dREN || bus.dWEN) begin
          state_d    = DATA;
          wr_d       = bus.dWEN;
          ren_d      = ~bus.dWEN;
          wen_d      = bus.dWEN;
          ramaddr_d  = bus.daddr;
          ramstore_d = bus.dstore;
        end else if (bus.iREN) begin
          state_d   = INSTR;
          wr_d      = 1'b0;
          ren_d     = 1'b1;
          ramaddr_d = bus.iaddr;
        end
      end

      DATA, INSTR: begin
        // An ERROR in the last counted cycle restarts the count rather than timing out.
        done = (bus.ramstate == ACCESS) || ((bus.ramstate != ERROR) && (cnt_q == CntMax));
        if (bus.ramstate != ACCESS) rdata = FillWord;
        if (done) begin
          state_d = RESP;
          if (bus.ramstate != ACCESS) memerr_d = 1'b1;
          if (state_q == INSTR) begin
            ihit_d  = 1'b1;
            iload_d = rdata;
          end else begin
            dhit_d = 1'b1;
            if (!wr_q) dload_d = rdata;
          end
        end else begin
          ren_d = ~wr_q;
          wen_d = wr_q;
          cnt_d = (bus.ramstate == ERROR) ? '0 : cnt_q + 1'b1;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      iload_q    <= '0;
      dload_q    <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      memerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      memerr_q   <= memerr_d;
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = ramaddr_q;
  assign bus.ramstore = ramstore_q;
  assign bus.memerr   = memerr_q;

endmodule
